// File: rtl/up_sample_interp.sv
// Stereo upsampler: one input sample becomes 2**FACTOR_LOG2 output samples, one per
// sample_tick, linearly interpolated per channel (or held when INTERP=0).

module up_sample_interp_lane #(
  parameter int CW          = 16,
  parameter int FACTOR_LOG2 = 1,
  parameter int INTERP      = 1
) (
  input  logic [CW-1:0]          prev,
  input  logic [CW-1:0]          curr,
  input  logic [FACTOR_LOG2-1:0] k,
  output logic [CW-1:0]          y
);
  localparam int PW = CW + 1 + FACTOR_LOG2;

  if (INTERP != 0) begin : g_lin
    logic signed [CW:0]   d;
    logic signed [PW-1:0] p, q;
    assign d = (CW+1)'($signed(curr)) - (CW+1)'($signed(prev));
    assign p = PW'(d) * PW'($signed({1'b0, k}));
    // floor division by F keeps y between prev and curr, so truncation never overflows
    assign q = p >>> FACTOR_LOG2;
    assign y = CW'(PW'($signed(prev)) + q);
  end else begin : g_hold
    assign y = curr;
  end
endmodule

module up_sample_interp #(
  parameter int DATA_WIDTH  = 32,
  parameter int FACTOR_LOG2 = 1,
  parameter int INTERP      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] audio_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] audio_out,
  output logic                  valid_out,
  output logic                  underrun
);
  localparam int CW = DATA_WIDTH / 2;
  localparam logic [FACTOR_LOG2-1:0] K_LAST = '1;

  typedef enum logic [1:0] {EMPTY, RUN, STALL} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   prev, curr, pend;
  logic [DATA_WIDTH-1:0]   prev_nxt, curr_nxt, out_val, y_word;
  logic                    pend_full, pend_full_nxt;
  logic [FACTOR_LOG2-1:0]  k, k_nxt;
  logic                    accept, consume, load_pend, out_load, under_nxt;
  logic [1:0][CW-1:0]      prev_ch, curr_ch, y_ch;

  assign ready_in = !pend_full;
  assign accept   = valid_in && !pend_full;

  // lane 1 = left (upper half), lane 0 = right
  assign prev_ch = prev;
  assign curr_ch = curr;
  assign y_word  = y_ch;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    up_sample_interp_lane #(
      .CW(CW), .FACTOR_LOG2(FACTOR_LOG2), .INTERP(INTERP)
    ) u_lane (
      .prev(prev_ch[g]), .curr(curr_ch[g]), .k(k), .y(y_ch[g])
    );
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    curr_nxt  = curr;
    k_nxt     = k;
    consume   = 1'b0;
    load_pend = 1'b0;
    out_load  = 1'b0;
    out_val   = audio_out;
    under_nxt = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          prev_nxt  = audio_in;
          curr_nxt  = audio_in;
          k_nxt     = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        load_pend = accept;
        if (sample_tick) begin
          out_load = 1'b1;
          out_val  = y_word;
          if (k != K_LAST)  k_nxt = k + FACTOR_LOG2'(1);
          else if (pend_full) consume = 1'b1;
          else state_nxt = STALL;
        end
      end
      STALL: begin
        load_pend = accept;
        if (sample_tick) begin
          out_load  = 1'b1;
          out_val   = curr;
          under_nxt = !pend_full;
          if (pend_full) begin
            consume   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (consume) begin
      prev_nxt = curr;
      curr_nxt = pend;
      k_nxt    = '0;
    end
    // accept wins over consume, though the handshake keeps them exclusive
    pend_full_nxt = load_pend ? 1'b1 : (consume ? 1'b0 : pend_full);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      prev      <= '0;
      curr      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      k         <= '0;
      audio_out <= '0;
      valid_out <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      curr      <= curr_nxt;
      pend_full <= pend_full_nxt;
      k         <= k_nxt;
      if (load_pend) pend <= audio_in;
      audio_out <= out_val;
      valid_out <= out_load;
      underrun  <= under_nxt;
    end
  end
endmodule
